clock_divider_bank: RTL

Synthesizable, parametrised successor to the behavioural testbench clock source: generates NUM_CH independent divided clock/enable outputs from one system clock, each with a runtime-programmable period, high time and start offset. A resync input aligns phases across channels. It sits beside the system clock root and feeds clock-enable and strobe timing to downstream logic and benches.

---
 rtl/clock_divider_bank.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/clock_divider_bank.sv
// ----------------------------------------------------------------------------
// clock_divider_bank
//
// Generates NUM_CH independent divided clock / strobe outputs from one system
// clock. Each channel has a programmable period, high time and start offset,
// and is gated by its own run enable. A shared resync pulse restarts all
// enabled channels on the same edge so their phases line up again.
//
// Configuration is double-buffered per channel. A write lands in a pending
// set, and the counter only takes the pending values at a safe point: while
// idle, on start/resync, or on a period wrap. A running output therefore never
// produces a partial or glitched period.
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   cfg_we      in   config write strobe (one cycle per write)
//   cfg_ch      in   channel targeted by the write (out-of-range is ignored)
//   cfg_period  in   period in clk cycles (0 behaves as 1)
//   cfg_high    in   high cycles per period (0 = always low, >= period = always high)
//   cfg_offset  in   cycles from start to the first high cycle
//   en          in   per-channel run enable (level)
//   resync      in   one-cycle pulse restarting every enabled channel
//   clk_out     out  registered divided outputs
//   tick        out  one-cycle pulse in the cycle clk_out rises
//   running     out  channel is in its RUN state
// ----------------------------------------------------------------------------
module clock_divider_bank #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 40,
    parameter int DEF_HIGH   = 20,
    parameter int DEF_OFFSET = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_offset,
    input  logic [NUM_CH-1:0] en,
    input  logic              resync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFSET = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] ocnt_q, ocnt_d;
            // active set, used by the running counter
            logic [CNT_W-1:0] per_q, per_d;
            logic [CNT_W-1:0] high_q, high_d;
            // pending set, written by the config port
            logic [CNT_W-1:0] per_pend_q, per_pend_d;
            logic [CNT_W-1:0] high_pend_q, high_pend_d;
            logic [CNT_W-1:0] off_pend_q, off_pend_d;
            logic             clk_out_q, clk_out_d;
            logic             tick_q;
            logic             running_q;

            logic             cfg_hit;
            logic             start;
            logic             wrap;
            logic [CNT_W-1:0] per_eff;
            logic [CNT_W-1:0] cnt_inc;

            assign cfg_hit = cfg_we && (cfg_ch == CH_W'(gi));
            // Idle channels start as soon as they are enabled; resync forces
            // the same start sequence from any state.
            assign start   = (state_q == ST_IDLE) || resync;
            assign per_eff = (per_q == '0) ? CNT_W'(1) : per_q;
            assign wrap    = (cnt_q == per_eff - CNT_W'(1));
            assign cnt_inc = cnt_q + CNT_W'(1);

            always_comb begin
                state_d     = state_q;
                cnt_d       = cnt_q;
                ocnt_d      = ocnt_q;
                per_d       = per_q;
                high_d      = high_q;
                clk_out_d   = clk_out_q;
                per_pend_d  = cfg_hit ? cfg_period : per_pend_q;
                high_pend_d = cfg_hit ? cfg_high   : high_pend_q;
                off_pend_d  = cfg_hit ? cfg_offset : off_pend_q;

                if (!en[gi]) begin
                    // Disabled: park in IDLE and keep the active set tracking
                    // the pending set so the next start uses fresh values.
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    ocnt_d    = '0;
                    per_d     = per_pend_q;
                    high_d    = high_pend_q;
                    clk_out_d = 1'b0;
                end else if (start) begin
                    per_d  = per_pend_q;
                    high_d = high_pend_q;
                    cnt_d  = '0;
                    if (off_pend_q == '0) begin
                        state_d   = ST_RUN;
                        ocnt_d    = '0;
                        clk_out_d = (high_pend_q != '0);
                    end else begin
                        state_d   = ST_OFFSET;
                        ocnt_d    = off_pend_q - CNT_W'(1);
                        clk_out_d = 1'b0;
                    end
                end else if (state_q == ST_OFFSET) begin
                    if (ocnt_q == '0) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        per_d     = per_pend_q;
                        high_d    = high_pend_q;
                        clk_out_d = (high_pend_q != '0);
                    end else begin
                        ocnt_d = ocnt_q - CNT_W'(1);
                    end
                end else begin
                    if (wrap) begin
                        // New period begins with the freshly loaded high
                        // time, so a changed H never yields a partial period.
                        cnt_d     = '0;
                        per_d     = per_pend_q;
                        high_d    = high_pend_q;
                        clk_out_d = (high_pend_q != '0);
                    end else begin
                        cnt_d     = cnt_inc;
                        clk_out_d = (cnt_inc < high_q);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    ocnt_q      <= '0;
                    per_q       <= CNT_W'(DEF_PERIOD);
                    high_q      <= CNT_W'(DEF_HIGH);
                    per_pend_q  <= CNT_W'(DEF_PERIOD);
                    high_pend_q <= CNT_W'(DEF_HIGH);
                    off_pend_q  <= CNT_W'(DEF_OFFSET);
                    clk_out_q   <= 1'b0;
                    tick_q      <= 1'b0;
                    running_q   <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    cnt_q       <= cnt_d;
                    ocnt_q      <= ocnt_d;
                    per_q       <= per_d;
                    high_q      <= high_d;
                    per_pend_q  <= per_pend_d;
                    high_pend_q <= high_pend_d;
                    off_pend_q  <= off_pend_d;
                    clk_out_q   <= clk_out_d;
                    tick_q      <= clk_out_d & ~clk_out_q;
                    running_q   <= (state_d == ST_RUN);
                end
            end

            assign clk_out[gi] = clk_out_q;
            assign tick[gi]    = tick_q;
            assign running[gi] = running_q;
        end
    endgenerate

endmodule
